// File: rtl/bram_sp_stream_reader.sv
// Sequential-read initiator for an ECP5 single-port block RAM. Reads are credit-limited
// against a small capture FIFO, and the FIFO drains as a valid/ready stream with a last marker.
module bram_sp_stream_reader #(
  parameter int unsigned DATA_WIDTH   = 18,
  parameter int unsigned ADDR_WIDTH   = 13,
  parameter logic [2:0]  CS_VALUE     = 3'b000,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                  i_CLK,
  input  logic                  i_RESET,
  input  logic                  i_START,
  input  logic [ADDR_WIDTH-1:0] i_BASE_ADDR,
  input  logic [ADDR_WIDTH:0]   i_LENGTH,
  output logic                  o_BUSY,
  output logic                  o_DONE,
  output logic                  o_BRAM_CLK_EN,
  output logic                  o_BRAM_WRITE_EN,
  output logic [2:0]            o_BRAM_CHIP_SELECT,
  output logic [ADDR_WIDTH-1:0] o_BRAM_ADDRESS,
  input  logic [DATA_WIDTH-1:0] i_BRAM_DATA,
  output logic [DATA_WIDTH-1:0] o_DATA,
  output logic                  o_VALID,
  input  logic                  i_READY,
  output logic                  o_LAST
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + READ_LATENCY + 1) + 1;
  localparam int unsigned LW = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [LW-1:0]           remain_q, remain_d;
  logic [LW-1:0]           beats_q, beats_d;
  logic [READ_LATENCY-1:0] tag_q, tag_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    clk_en_q, clk_en_d;
  logic [2:0]              cs_q, cs_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];

  logic [CW-1:0] inflight;
  logic          issue;
  logic          push;
  logic          pop;
  logic          fifo_empty;
  logic          last_beat;

  // Credit check counts only registered occupancy, so a same-cycle pop never frees a slot early.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight = inflight + CW'(tag_q[i]);
    end
    fifo_empty = (count_q == '0);
    pop        = !fifo_empty && i_READY;
    push       = tag_q[READ_LATENCY-1];
    last_beat  = !fifo_empty && (beats_q == LW'(1));
    issue      = (state_q == S_ISSUE) && ((count_q + inflight) < CW'(FIFO_DEPTH));
  end

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    beats_d  = beats_q;
    done_d   = 1'b0;

    tag_d[0] = issue;
    for (int i = 1; i < READ_LATENCY; i++) begin
      tag_d[i] = tag_q[i-1];
    end

    unique case (state_q)
      S_IDLE: begin
        if (i_START) begin
          if (i_LENGTH != '0) begin
            addr_d   = i_BASE_ADDR;
            remain_d = i_LENGTH;
            beats_d  = i_LENGTH;
            state_d  = S_ISSUE;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (issue) begin
          addr_d   = addr_q + ADDR_WIDTH'(1);
          remain_d = remain_q - LW'(1);
          if (remain_q == LW'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Popping the final beat implies every read has landed and the FIFO is now empty.
        if (pop && last_beat) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) beats_d = beats_d - LW'(1);

    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);

    busy_d   = (state_d != S_IDLE);
    cs_d     = busy_d ? CS_VALUE : ~CS_VALUE;
    clk_en_d = (state_d == S_ISSUE) || ((state_d == S_DRAIN) && (tag_d != '0));
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_CLK or negedge i_RESET) begin
    if (!i_RESET) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      beats_q  <= '0;
      tag_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      clk_en_q <= 1'b0;
      cs_q     <= ~CS_VALUE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      beats_q  <= beats_d;
      tag_q    <= tag_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      clk_en_q <= clk_en_d;
      cs_q     <= cs_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: FIFO storage has no reset; the cleared count masks stale entries and o_DATA is forced to 0 when empty.
  always_ff @(posedge i_CLK) begin
    if (push) mem_q[wr_ptr_q] <= i_BRAM_DATA;
  end

  assign o_BUSY             = busy_q;
  assign o_DONE             = done_q;
  assign o_BRAM_CLK_EN      = clk_en_q;
  assign o_BRAM_WRITE_EN    = 1'b0;
  assign o_BRAM_CHIP_SELECT = cs_q;
  assign o_BRAM_ADDRESS     = addr_q;
  assign o_VALID            = !fifo_empty;
  assign o_DATA             = fifo_empty ? '0 : mem_q[rd_ptr_q];
  assign o_LAST             = last_beat;

  fifo_no_overflow: assert property (@(posedge i_CLK) disable iff (!i_RESET)
    !(push && (count_q == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_bram_sp_stream_reader.sv
// Directed bench for bram_sp_stream_reader: one instance with READ_LATENCY=1 and one with
// READ_LATENCY=2, each reading from a behavioural RAM that returns addr+0x100.
module tb_bram_sp_stream_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [12:0] base;
  logic [13:0] length;
  logic        ready;

  logic        d1_busy, d1_done, d1_ce, d1_we, d1_valid, d1_last;
  logic [2:0]  d1_cs;
  logic [12:0] d1_addr;
  logic [17:0] d1_ram_q, d1_data;

  logic        d2_busy, d2_done, d2_ce, d2_we, d2_valid, d2_last;
  logic [2:0]  d2_cs;
  logic [12:0] d2_addr;
  logic [17:0] d2_stage, d2_ram_q, d2_data;

  bit          sel;
  logic        mon_busy, mon_done, mon_ce, mon_we, mon_valid, mon_last;
  logic [2:0]  mon_cs;
  logic [12:0] mon_addr;
  logic [17:0] mon_data;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [17:0] beat_data [$];
  int          beat_cyc  [$];
  bit          beat_last [$];
  logic [12:0] addr_at [64];
  bit          ce_at   [64];
  bit          busy_at [64];
  logic [2:0]  cs_at   [64];
  int          done_cyc;
  bit          ever_ce, ever_valid, ever_busy;

  always #5 clk = ~clk;

  bram_sp_stream_reader u_dut1 (
    .i_CLK(clk), .i_RESET(rst_n), .i_START(start), .i_BASE_ADDR(base), .i_LENGTH(length),
    .o_BUSY(d1_busy), .o_DONE(d1_done), .o_BRAM_CLK_EN(d1_ce), .o_BRAM_WRITE_EN(d1_we),
    .o_BRAM_CHIP_SELECT(d1_cs), .o_BRAM_ADDRESS(d1_addr), .i_BRAM_DATA(d1_ram_q),
    .o_DATA(d1_data), .o_VALID(d1_valid), .i_READY(ready), .o_LAST(d1_last)
  );

  bram_sp_stream_reader #(.READ_LATENCY(2)) u_dut2 (
    .i_CLK(clk), .i_RESET(rst_n), .i_START(start), .i_BASE_ADDR(base), .i_LENGTH(length),
    .o_BUSY(d2_busy), .o_DONE(d2_done), .o_BRAM_CLK_EN(d2_ce), .o_BRAM_WRITE_EN(d2_we),
    .o_BRAM_CHIP_SELECT(d2_cs), .o_BRAM_ADDRESS(d2_addr), .i_BRAM_DATA(d2_ram_q),
    .o_DATA(d2_data), .o_VALID(d2_valid), .i_READY(ready), .o_LAST(d2_last)
  );

  function automatic logic [17:0] ram_word(input logic [12:0] a);
    return {5'b0, a} + 18'h100;
  endfunction

  // RAM contents are addr+0x100; the second model adds the optional output register.
  always @(posedge clk) if (d1_ce) d1_ram_q <= ram_word(d1_addr);
  always @(posedge clk) if (d2_ce) begin
    d2_stage <= ram_word(d2_addr);
    d2_ram_q <= d2_stage;
  end

  assign mon_busy  = sel ? d2_busy  : d1_busy;
  assign mon_done  = sel ? d2_done  : d1_done;
  assign mon_ce    = sel ? d2_ce    : d1_ce;
  assign mon_we    = sel ? d2_we    : d1_we;
  assign mon_valid = sel ? d2_valid : d1_valid;
  assign mon_last  = sel ? d2_last  : d1_last;
  assign mon_cs    = sel ? d2_cs    : d1_cs;
  assign mon_addr  = sel ? d2_addr  : d1_addr;
  assign mon_data  = sel ? d2_data  : d1_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_reset_outputs();
    check("rst_busy",  32'(mon_busy),  32'd0);
    check("rst_done",  32'(mon_done),  32'd0);
    check("rst_valid", 32'(mon_valid), 32'd0);
    check("rst_last",  32'(mon_last),  32'd0);
    check("rst_ce",    32'(mon_ce),    32'd0);
    check("rst_we",    32'(mon_we),    32'd0);
    check("rst_cs",    32'(mon_cs),    32'h7);
    check("rst_addr",  32'(mon_addr),  32'h0);
    check("rst_data",  32'(mon_data),  32'h0);
  endtask

  // Start is driven in cycle 0; returns early in cycle 1.
  task automatic start_xfer(input logic [12:0] b, input logic [13:0] len);
    tick();
    start  = 1'b1;
    base   = b;
    length = len;
    cyc    = 0;
    tick();
    start  = 1'b0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 50 && (d1_busy || d2_busy); n++) tick();
    check("idle", {30'd0, d1_busy, d2_busy}, 32'd0);
  endtask

  // ready_mode: 0 = high, 1 = low in cycles 3..8, 2 = high on odd cycles only.
  task automatic collect(input int ready_mode, input int glitch_cyc);
    bit          stall_prev;
    logic [17:0] held;
    beat_data.delete();
    beat_cyc.delete();
    beat_last.delete();
    done_cyc   = -1;
    ever_ce    = 1'b0;
    ever_valid = 1'b0;
    ever_busy  = 1'b0;
    stall_prev = 1'b0;
    held       = '0;
    for (int n = 0; n < 200; n++) begin
      case (ready_mode)
        0:       ready = 1'b1;
        1:       ready = !(cyc >= 3 && cyc <= 8);
        default: ready = cyc[0];
      endcase
      if (cyc == glitch_cyc) begin
        start  = 1'b1;
        base   = 13'h0100;
        length = 14'd5;
      end else begin
        start = 1'b0;
      end
      #1;
      if (cyc < 64) begin
        addr_at[cyc] = mon_addr;
        ce_at[cyc]   = mon_ce;
        busy_at[cyc] = mon_busy;
        cs_at[cyc]   = mon_cs;
      end
      if (mon_ce)    ever_ce    = 1'b1;
      if (mon_valid) ever_valid = 1'b1;
      if (mon_busy)  ever_busy  = 1'b1;
      if (stall_prev) begin
        check("stall_valid", 32'(mon_valid), 32'd1);
        check("stall_data",  32'(mon_data),  32'(held));
      end
      stall_prev = mon_valid && !ready;
      held       = mon_data;
      if (mon_valid && ready) begin
        beat_data.push_back(mon_data);
        beat_cyc.push_back(cyc);
        beat_last.push_back(mon_last);
      end
      if (mon_done && done_cyc < 0) done_cyc = cyc;
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
      tick();
    end
    start = 1'b0;
    check("done_seen", 32'(done_cyc >= 0), 32'd1);
  endtask

  initial begin
    int nlast;
    rst_n  = 1'b0;
    start  = 1'b0;
    base   = '0;
    length = '0;
    ready  = 1'b1;
    sel    = 1'b0;
    tick();
    tick();
    check_reset_outputs();
    rst_n = 1'b1;
    tick();

    // Base 0x10, length 4, ready high.
    start_xfer(13'h0010, 14'd4);
    collect(0, -1);
    for (int k = 0; k < 4; k++) begin
      check("t1_addr", 32'(addr_at[1+k]), 32'h10 + 32'(k));
      check("t1_ce",   32'(ce_at[1+k]),   32'd1);
    end
    check("t1_cs", 32'(cs_at[1]), 32'h0);
    check("t1_nbeats", 32'(beat_data.size()), 32'd4);
    for (int k = 0; k < 4 && k < beat_data.size(); k++) begin
      check("t1_data", 32'(beat_data[k]), 32'h110 + 32'(k));
      check("t1_bcyc", 32'(beat_cyc[k]),  32'd3 + 32'(k));
      check("t1_last", 32'(beat_last[k]), 32'(k == 3));
    end
    check("t1_done_cyc", 32'(done_cyc), 32'd7);
    check("t1_busy6", 32'(busy_at[6]), 32'd1);
    check("t1_busy7", 32'(busy_at[7]), 32'd0);
    wait_idle();

    // Same transfer with ready low in cycles 3..8.
    start_xfer(13'h0010, 14'd4);
    collect(1, -1);
    check("t2_nbeats", 32'(beat_data.size()), 32'd4);
    for (int k = 0; k < 4 && k < beat_data.size(); k++) begin
      check("t2_data", 32'(beat_data[k]), 32'h110 + 32'(k));
      check("t2_bcyc", 32'(beat_cyc[k]),  32'd9 + 32'(k));
      check("t2_last", 32'(beat_last[k]), 32'(k == 3));
    end
    check("t2_done_cyc", 32'(done_cyc), 32'd13);
    wait_idle();

    // Address wrap 0x1FFE -> 0x0001.
    start_xfer(13'h1FFE, 14'd4);
    collect(0, -1);
    check("t3_addr0", 32'(addr_at[1]), 32'h1FFE);
    check("t3_addr1", 32'(addr_at[2]), 32'h1FFF);
    check("t3_addr2", 32'(addr_at[3]), 32'h0000);
    check("t3_addr3", 32'(addr_at[4]), 32'h0001);
    check("t3_nbeats", 32'(beat_data.size()), 32'd4);
    if (beat_data.size() == 4) begin
      check("t3_data0", 32'(beat_data[0]), 32'h20FE);
      check("t3_data1", 32'(beat_data[1]), 32'h20FF);
      check("t3_data2", 32'(beat_data[2]), 32'h0100);
      check("t3_data3", 32'(beat_data[3]), 32'h0101);
    end
    wait_idle();

    // Zero length.
    start_xfer(13'h0055, 14'd0);
    collect(0, -1);
    check("t4_done_cyc", 32'(done_cyc),   32'd1);
    check("t4_no_ce",    32'(ever_ce),    32'd0);
    check("t4_no_valid", 32'(ever_valid), 32'd0);
    check("t4_no_busy",  32'(ever_busy),  32'd0);
    wait_idle();

    // READ_LATENCY=2 instance, length 8, ready toggling.
    sel = 1'b1;
    start_xfer(13'h0040, 14'd8);
    collect(2, -1);
    check("t5_nbeats", 32'(beat_data.size()), 32'd8);
    nlast = 0;
    for (int k = 0; k < beat_data.size(); k++) begin
      if (k < 8) check("t5_data", 32'(beat_data[k]), 32'h140 + 32'(k));
      if (beat_last[k]) nlast++;
    end
    check("t5_nlast", 32'(nlast), 32'd1);
    if (beat_data.size() == 8) check("t5_last8", 32'(beat_last[7]), 32'd1);
    sel = 1'b0;
    ready = 1'b1;
    wait_idle();

    // Reset in cycle 5 of a 16-word transfer, then base 0x20 length 2 with a start pulse while busy.
    start_xfer(13'h0030, 14'd16);
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    tick();
    check_reset_outputs();
    rst_n = 1'b1;
    tick();
    tick();
    start_xfer(13'h0020, 14'd2);
    collect(0, 2);
    check("t6_nbeats", 32'(beat_data.size()), 32'd2);
    if (beat_data.size() == 2) begin
      check("t6_data0", 32'(beat_data[0]), 32'h120);
      check("t6_data1", 32'(beat_data[1]), 32'h121);
      check("t6_last1", 32'(beat_last[1]), 32'd1);
    end
    check("t6_done_cyc", 32'(done_cyc), 32'd5);
    tick();
    tick();
    check("t6_idle_after", 32'(mon_busy),  32'd0);
    check("t6_no_valid",   32'(mon_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_sp_stream_reader.md
# bram_sp_stream_reader

Read-side initiator for an ECP5 single-port 8K block RAM port. Given a base address and a word count, it issues sequential reads into the RAM's clock-enable/chip-select/address interface. It captures the returned words after the fixed read latency and presents them as a valid/ready stream with a last marker. A small internal FIFO absorbs in-flight reads, so downstream backpressure never drops data.

## Interface
- DATA_WIDTH, 18: RAM word width.
- ADDR_WIDTH, 13: RAM address width.
- CS_VALUE, 3'b000: value driven on the RAM chip-select bus while busy.
- READ_LATENCY, 1: cycles from address issue to valid RAM data. Legal values are 1 (no output register) or 2 (output register).
- FIFO_DEPTH, 4: capture FIFO depth. Must be ≥ READ_LATENCY+2; power of two.
- i_CLK  in  1  single clock; all logic is rising-edge.
- i_RESET  in  1  asynchronous, active-low reset.
- i_START  in  1  one-cycle request. Sampled only in IDLE.
- i_BASE_ADDR  in  ADDR_WIDTH  first word address. Sampled with i_START.
- i_LENGTH  in  ADDR_WIDTH+1  word count, 0..2^ADDR_WIDTH. Sampled with i_START.
- o_BUSY  out  1  high from the cycle after an accepted start until o_DONE.
- o_DONE  out  1  one-cycle pulse when the transfer completes.
- o_BRAM_CLK_EN  out  1  RAM clock enable.
- o_BRAM_WRITE_EN  out  1  constant 0.
- o_BRAM_CHIP_SELECT  out  3  CS_VALUE while busy, otherwise ~CS_VALUE.
- o_BRAM_ADDRESS  out  ADDR_WIDTH  RAM address.
- i_BRAM_DATA  in  DATA_WIDTH  RAM read data.
- o_DATA  out  DATA_WIDTH  stream data.
- o_VALID  out  1  stream valid.
- i_READY  in  1  stream ready.
- o_LAST  out  1  marks the final word of the transfer; qualified by o_VALID.

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE:
  - i_START with i_LENGTH≠0 latches the base address and the remaining count, then moves to ISSUE.
  - i_START with i_LENGTH=0 produces an o_DONE pulse the next cycle, stays in IDLE, and issues no reads.
- ISSUE:
  - o_BRAM_CLK_EN=1 throughout.
  - A read is issued in a cycle when fifo_count + inflight < FIFO_DEPTH. Pops in the same cycle are not counted.
  - On an issue: o_BRAM_ADDRESS holds the current address, a tag enters a READ_LATENCY-deep valid shift register, the address increments modulo 2^ADDR_WIDTH (wrap 8191→0 is legal), and the remaining count decrements.
  - A non-issue cycle holds the address. Any re-read it causes is untagged and discarded.
  - The last issue moves the FSM to DRAIN.
- DRAIN:
  - o_BRAM_CLK_EN stays 1 until the shift register is empty, so registered-output RAMs still advance.
  - The FSM moves to IDLE when inflight=0, the FIFO is empty, and the last beat has been accepted; o_DONE pulses on that transition.
- Capture: a tagged i_BRAM_DATA is written into the FIFO in the cycle its tag exits the shift register. The credit rule guarantees the FIFO never overflows; overflow is a design error checked by assertion.
- Stream: o_VALID = FIFO not empty, and o_DATA is the FIFO head. A beat transfers when o_VALID && i_READY. o_DATA is held stable while o_VALID && !i_READY.
- o_LAST is computed from a beat counter and asserts on beat i_LENGTH.
- i_START while busy is ignored.
- Outputs never depend combinationally on i_READY except through FIFO pop.
- Reset, including mid-transfer: the FSM goes to IDLE; FIFO, tags and counters clear; in-flight data is discarded.

## Timing
- Reset values:
  - o_BUSY=0, o_DONE=0, o_VALID=0, o_LAST=0.
  - o_BRAM_CLK_EN=0, o_BRAM_WRITE_EN=0.
  - o_BRAM_CHIP_SELECT=~CS_VALUE, o_BRAM_ADDRESS=0, o_DATA=0.
- Start sampled in cycle 0:
  - o_BUSY and the first issue occur in cycle 1.
  - Data for the first issue is on i_BRAM_DATA in cycle 1+READ_LATENCY and is written to the FIFO at the end of that cycle.
  - First o_VALID is in cycle 2+READ_LATENCY.
- With i_READY held high, one word per cycle is sustained with no bubbles.
- N words with READ_LATENCY=1 and i_READY high:
  - Last beat in cycle N+2.
  - o_DONE in cycle N+3.
  - o_BUSY falls in cycle N+3, coincident with o_DONE.
- A new i_START is accepted in the cycle after o_DONE.

## Test plan
- Base 0x0010, length 4, READ_LATENCY=1, ready high, RAM preloaded with addr+0x100 → addresses 0x10..0x13 issued in cycles 1..4; beats 0x110..0x113 in cycles 3..6; o_LAST in cycle 6; o_DONE in cycle 7.
- Same transfer with i_READY low in cycles 3..8 → issue stalls after 4 outstanding; no beat lost or duplicated; o_DATA stable while stalled; order preserved.
- Base 0x1FFE, length 4 → addresses 0x1FFE, 0x1FFF, 0x0000, 0x0001; data in that order.
- Length 0 → o_DONE in cycle 1; o_BRAM_CLK_EN never high; no o_VALID.
- READ_LATENCY=2, length 8, i_READY toggling 1/0 → 8 correct beats in order; o_LAST only on the 8th.
- Reset asserted in cycle 5 of a 16-word transfer, then a new start (base 0x0020, length 2) → all outputs at reset values during reset; only 0x120, 0x121 delivered afterwards; an i_START pulsed while busy has no effect.
